// File: rtl/apb_gpio_irq.sv
// apb_gpio_irq: parametrised APB GPIO controller for the bus1 peripheral segment.
// Features: input synchroniser, per-pin debounce filter, W1S/W1C output registers,
// and per-pin level/edge/both-edge interrupts with polarity and RW1C pending flags.

package apb_gpio_irq_pkg;

    // Address window handed down by the bus1 bridge
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] mask;
    } mapinfo_type;

    // Plug-and-play descriptor reported back to the bridge
    typedef struct packed {
        logic [1:0]  descrtype;
        logic [15:0] did;
        logic [31:0] addr;
        logic [31:0] mask;
    } dev_config_type;

    localparam logic [1:0] PNP_SLAVE = 2'b10;

    typedef struct packed {
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_in_type;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
    } apb_out_type;

endpackage

// Per-pin debounce filter: the stable value follows the synchronised input only
// after it has differed for LIMIT consecutive cycles; LIMIT=0 bypasses the filter.
module apb_gpio_irq_dbnc #(
    parameter int dbnc_bits = 8
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_sync,
    input  logic [dbnc_bits-1:0] i_limit,
    output logic                 o_stable
);

    logic [dbnc_bits-1:0] cnt;
    logic [dbnc_bits:0]   cnt_nxt;

    // One extra bit so the commit test also works when LIMIT was lowered below cnt
    assign cnt_nxt = {1'b0, cnt} + (dbnc_bits+1)'(1);

    // Count cycles of disagreement, commit once the run reaches LIMIT
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            cnt      <= '0;
            o_stable <= 1'b0;
        end else if (i_limit == '0) begin
            cnt      <= '0;
            o_stable <= i_sync;
        end else if (i_sync == o_stable) begin
            cnt      <= '0;
        end else if (cnt_nxt >= {1'b0, i_limit}) begin
            cnt      <= '0;
            o_stable <= i_sync;
        end else begin
            cnt      <= cnt_nxt[dbnc_bits-1:0];
        end
    end

endmodule

module apb_gpio_irq
    import apb_gpio_irq_pkg::*;
#(
    parameter int                   width       = 12,
    parameter int                   sync_stages = 2,
    parameter int                   dbnc_bits   = 8,
    parameter logic [dbnc_bits-1:0] dbnc_reset  = '0,
    parameter logic [15:0]          did         = 16'h0000
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  mapinfo_type      i_mapinfo,
    output dev_config_type   o_cfg,
    input  apb_in_type       i_apbi,
    output apb_out_type      o_apbo,
    input  logic [width-1:0] i_gpio,
    output logic [width-1:0] o_gpio,
    output logic [width-1:0] o_gpio_dir,
    output logic [width-1:0] o_irq,
    output logic             o_irq_any
);

    localparam logic [9:0] A_INPUT    = 10'h000;
    localparam logic [9:0] A_DIR      = 10'h001;
    localparam logic [9:0] A_OUT      = 10'h002;
    localparam logic [9:0] A_OUT_SET  = 10'h003;
    localparam logic [9:0] A_OUT_CLR  = 10'h004;
    localparam logic [9:0] A_IRQ_EN   = 10'h005;
    localparam logic [9:0] A_IRQ_TYPE = 10'h006;
    localparam logic [9:0] A_IRQ_POL  = 10'h007;
    localparam logic [9:0] A_IRQ_BOTH = 10'h008;
    localparam logic [9:0] A_PENDING  = 10'h009;
    localparam logic [9:0] A_DBNC     = 10'h00A;

    logic [width-1:0] dir_q, out_q, en_q, type_q, pol_q, both_q, pend_q;
    logic [dbnc_bits-1:0] limit_q;

    logic [sync_stages-1:0][width-1:0] sync_q;
    logic [width-1:0] sync, stable, prev;

    logic [31:0]      prdata_q;
    logic             pready_q;

    logic             setup, wr;
    logic [9:0]       widx;
    logic [31:0]      bm, wd, rd;
    logic [width-1:0] mbits, wbits, clr;
    logic [width-1:0] rise, fall, edge_set, set;

    assign setup = i_apbi.psel & ~i_apbi.penable;
    assign wr    = i_apbi.psel &  i_apbi.penable & i_apbi.pwrite;
    assign widx  = i_apbi.paddr[11:2];

    // Byte-lane mask from pstrb; wd is the write data restricted to enabled lanes
    always_comb begin
        bm = '0;
        for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{i_apbi.pstrb[b]}};
    end

    assign wd    = i_apbi.pwdata & bm;
    assign mbits = bm[width-1:0];
    assign wbits = wd[width-1:0];

    // ---------------- input path ----------------

    // Synchroniser chain; sync is the last stage
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) sync_q <= '0;
        else         sync_q <= {sync_q[sync_stages-2:0], i_gpio};
    end

    assign sync = sync_q[sync_stages-1];

    for (genvar i = 0; i < width; i++) begin : g_pin
        apb_gpio_irq_dbnc #(.dbnc_bits(dbnc_bits)) u_dbnc (
            .i_clk    (i_clk),
            .i_nrst   (i_nrst),
            .i_sync   (sync[i]),
            .i_limit  (limit_q),
            .o_stable (stable[i])
        );
    end

    // Previous stable value for edge detection
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) prev <= '0;
        else         prev <= stable;
    end

    // ---------------- interrupt set logic ----------------

    // POL selects falling edge / low level; BOTH overrides POL for edge pins
    always_comb begin
        rise     = stable & ~prev;
        fall     = ~stable & prev;
        edge_set = (both_q & (rise | fall)) | (~both_q & ((pol_q & fall) | (~pol_q & rise)));
        set      = (type_q & edge_set) | (~type_q & (stable ^ pol_q));
    end

    assign clr = (wr && widx == A_PENDING) ? wbits : '0;

    // Pending flags: a set on the same edge as a W1C clear wins
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) pend_q <= '0;
        else         pend_q <= (pend_q & ~clr) | set;
    end

    assign o_irq     = pend_q & en_q;
    assign o_irq_any = |o_irq;

    // ---------------- register writes ----------------

    // Control registers commit on the access-phase edge, byte lanes per pstrb
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            dir_q   <= '0;
            out_q   <= '0;
            en_q    <= '0;
            type_q  <= '0;
            pol_q   <= '0;
            both_q  <= '0;
            limit_q <= dbnc_reset;
        end else if (wr) begin
            case (widx)
                A_DIR:      dir_q   <= (dir_q  & ~mbits) | wbits;
                A_OUT:      out_q   <= (out_q  & ~mbits) | wbits;
                A_OUT_SET:  out_q   <= out_q | wbits;
                A_OUT_CLR:  out_q   <= out_q & ~wbits;
                A_IRQ_EN:   en_q    <= (en_q   & ~mbits) | wbits;
                A_IRQ_TYPE: type_q  <= (type_q & ~mbits) | wbits;
                A_IRQ_POL:  pol_q   <= (pol_q  & ~mbits) | wbits;
                A_IRQ_BOTH: both_q  <= (both_q & ~mbits) | wbits;
                A_DBNC:     limit_q <= (limit_q & ~bm[dbnc_bits-1:0]) | wd[dbnc_bits-1:0];
                default: ;
            endcase
        end
    end

    assign o_gpio     = out_q;
    assign o_gpio_dir = dir_q;

    // ---------------- read path ----------------

    // Read mux; write-only and unmapped offsets read 0
    always_comb begin
        rd = '0;
        case (widx)
            A_INPUT:    rd[width-1:0]     = stable;
            A_DIR:      rd[width-1:0]     = dir_q;
            A_OUT:      rd[width-1:0]     = out_q;
            A_IRQ_EN:   rd[width-1:0]     = en_q;
            A_IRQ_TYPE: rd[width-1:0]     = type_q;
            A_IRQ_POL:  rd[width-1:0]     = pol_q;
            A_IRQ_BOTH: rd[width-1:0]     = both_q;
            A_PENDING:  rd[width-1:0]     = pend_q;
            A_DBNC:     rd[dbnc_bits-1:0] = limit_q;
            default: ;
        endcase
    end

    // Read data captured in setup; pready raised for exactly the access cycle
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            prdata_q <= '0;
            pready_q <= 1'b0;
        end else begin
            pready_q <= setup;
            prdata_q <= setup ? rd : '0;
        end
    end

    assign o_apbo = '{prdata: prdata_q, pready: pready_q, pslverr: 1'b0};
    assign o_cfg  = '{descrtype: PNP_SLAVE, did: did, addr: i_mapinfo.addr, mask: i_mapinfo.mask};

    // Address bits outside the decoded window and lanes above width are don't-care
    logic unused_ok;
    assign unused_ok = ^{i_apbi.paddr[31:12], i_apbi.paddr[1:0], wd};

endmodule
